dff_resp_checker: RTL and testbench

DFF_RESP_CHECKER -- requirements
Module: dff_resp_checker

---
 rtl/dff_resp_checker.sv | 114 +++++++++++
 tb/tb_dff_resp_checker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_resp_checker.sv
// rtl/dff_resp_checker.sv - scan-style response checker for a set-able D flip-flop cell
// Optional macro CHK_COMPLEMENT_EN also checks QN against ~Q on every checked vector.
module dff_resp_checker #(
    parameter int NUM_VEC = 8,
    parameter int IW      = 4
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          START,
    input  logic          VLD,
    input  logic          D,
    input  logic          SN,
    input  logic          EDGE,
    input  logic          Q,
    input  logic          QN,
    output logic          BUSY,
    output logic          DONE,
    output logic          PASS,
    output logic [3:0]    ERR_CNT,
    output logic [IW-1:0] FAIL_IDX,
    output logic [IW-1:0] VEC_CNT
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // One extra count bit so a full run of 2**IW vectors can still be detected.
    localparam logic [IW:0] CNT_LAST = (IW+1)'(NUM_VEC - 1);
    localparam logic [IW:0] CNT_ONE  = (IW+1)'(1);

    state_t      state;
    logic [IW:0] cnt;
    logic        known;
    logic        exp_q;
    logic        fail_seen;

    logic        known_n;
    logic        exp_n;
    logic        q_bad;
    logic        qn_bad;
    logic        mism;
    logic        last;
    logic [3:0]  err_n;

    always_comb begin
        known_n = known;
        exp_n   = exp_q;
        if (!SN) begin
            exp_n   = 1'b1;
            known_n = 1'b1;
        end else if (EDGE) begin
            exp_n   = D;
            known_n = 1'b1;
        end
        // Case inequality so an X/Z response is always treated as wrong.
        q_bad = (Q !== exp_n);
`ifdef CHK_COMPLEMENT_EN
        qn_bad = (QN !== ~Q);
`else
        qn_bad = 1'b0;
`endif
        mism  = known_n && (q_bad || qn_bad);
        last  = (cnt == CNT_LAST);
        err_n = (mism && (ERR_CNT != 4'hf)) ? ERR_CNT + 4'd1 : ERR_CNT;
    end

`ifndef CHK_COMPLEMENT_EN
    logic unused_qn;
    assign unused_qn = QN;
`endif

    assign VEC_CNT = cnt[IW-1:0];

    always_ff @(posedge CK) begin
        if (RST) begin
            state     <= S_IDLE;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            ERR_CNT   <= 4'd0;
            FAIL_IDX  <= '0;
            cnt       <= '0;
            known     <= 1'b0;
            exp_q     <= 1'b0;
            fail_seen <= 1'b0;
        end else if (START) begin
            // START from any state (re)opens a run; a VLD in this cycle is dropped.
            state     <= S_RUN;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            ERR_CNT   <= 4'd0;
            FAIL_IDX  <= '0;
            cnt       <= '0;
            known     <= 1'b0;
            fail_seen <= 1'b0;
        end else if (state == S_RUN && VLD) begin
            exp_q   <= exp_n;
            known   <= known_n;
            ERR_CNT <= err_n;
            cnt     <= cnt + CNT_ONE;
            if (mism && !fail_seen) begin
                FAIL_IDX  <= cnt[IW-1:0];
                fail_seen <= 1'b1;
            end
            if (last) begin
                state <= S_DONE;
                BUSY  <= 1'b0;
                DONE  <= 1'b1;
                PASS  <= (err_n == 4'd0);
            end
        end
    end

endmodule

// File: tb/tb_dff_resp_checker.sv
// tb/tb_dff_resp_checker.sv - scoreboard bench for dff_resp_checker (8- and 16-vector instances)
module tb_dff_resp_checker;

    logic CK = 1'b0;
    logic RST = 1'b1, start8 = 1'b0, start16 = 1'b0, VLD = 1'b0;
    logic D = 1'b0, SN = 1'b1, EDGE = 1'b0, Q = 1'b0, QN = 1'b1;
    logic busy8, done8, pass8, busy16, done16, pass16;
    logic [3:0] err8, fidx8, vcnt8, err16, fidx16, vcnt16;

    always #5 CK = ~CK;

    dff_resp_checker #(.NUM_VEC(8), .IW(4)) u8 (
        .CK(CK), .RST(RST), .START(start8), .VLD(VLD), .D(D), .SN(SN), .EDGE(EDGE),
        .Q(Q), .QN(QN), .BUSY(busy8), .DONE(done8), .PASS(pass8),
        .ERR_CNT(err8), .FAIL_IDX(fidx8), .VEC_CNT(vcnt8));

    dff_resp_checker #(.NUM_VEC(16), .IW(4)) u16 (
        .CK(CK), .RST(RST), .START(start16), .VLD(VLD), .D(D), .SN(SN), .EDGE(EDGE),
        .Q(Q), .QN(QN), .BUSY(busy16), .DONE(done16), .PASS(pass16),
        .ERR_CNT(err16), .FAIL_IDX(fidx16), .VEC_CNT(vcnt16));

    typedef struct { logic d; logic sn; logic edg; logic q; logic qn; } vec_t;
    typedef struct { logic pass; int err; int fidx; int vcnt; } res_t;

    res_t exp8[$];
    res_t exp16[$];
    res_t r8, r16;
    vec_t vecs[16];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic pd8 = 1'b0, pd16 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Reference: walk the vectors applying the cell's behaviour directly.
    function automatic res_t model(input int n);
        res_t r;
        bit   known = 0;
        logic e = 1'b0;
        bit   seen = 0;
        bit   bad;
        r.err = 0;
        r.fidx = 0;
        for (int i = 0; i < n; i++) begin
            if (vecs[i].sn == 1'b0) begin e = 1'b1; known = 1; end
            else if (vecs[i].edg == 1'b1) begin e = vecs[i].d; known = 1; end
            if (known) begin
                bad = (vecs[i].q !== e);
`ifdef CHK_COMPLEMENT_EN
                if (vecs[i].qn !== ~vecs[i].q) bad = 1;
`endif
                if (bad) begin
                    if (!seen) r.fidx = i;
                    seen = 1;
                    if (r.err < 15) r.err++;
                end
            end
        end
        r.pass = (r.err == 0);
        r.vcnt = n % 16;
        return r;
    endfunction

    task automatic fill_good(input int n);
        bit   k = 0;
        logic e = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (vecs[i].sn == 1'b0) begin e = 1'b1; k = 1; end
            else if (vecs[i].edg == 1'b1) begin e = vecs[i].d; k = 1; end
            vecs[i].q  = k ? e : 1'b0;
            vecs[i].qn = ~vecs[i].q;
        end
    endtask

    task automatic gen_random(input int n);
        for (int i = 0; i < n; i++) begin
            vecs[i].d   = 1'($urandom_range(0, 1));
            vecs[i].sn  = ($urandom_range(0, 3) != 0);
            vecs[i].edg = 1'($urandom_range(0, 1));
        end
        fill_good(n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                vecs[i].q  = ~vecs[i].q;
                vecs[i].qn = ~vecs[i].q;
            end
            if ($urandom_range(0, 7) == 0) vecs[i].qn = vecs[i].q;
        end
    endtask

    task automatic pulse_start(input bit big);
        @(posedge CK); #1;
        VLD = 1'b0;
        if (big) start16 = 1'b1; else start8 = 1'b1;
        @(posedge CK); #1;
        start8 = 1'b0;
        start16 = 1'b0;
    endtask

    task automatic send(input int i);
        int gap = $urandom_range(0, 2);
        repeat (gap) begin @(posedge CK); #1; end
        D = vecs[i].d; SN = vecs[i].sn; EDGE = vecs[i].edg; Q = vecs[i].q; QN = vecs[i].qn;
        VLD = 1'b1;
        @(posedge CK); #1;
        VLD = 1'b0;
    endtask

    task automatic run(input int n, input bit big);
        if (big) exp16.push_back(model(n)); else exp8.push_back(model(n));
        pulse_start(big);
        for (int i = 0; i < n; i++) send(i);
        repeat (2) begin @(posedge CK); #1; end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy8, 0);
        check({tag, "_done"}, done8, 0);
        check({tag, "_pass"}, pass8, 0);
        check({tag, "_err"},  err8, 0);
        check({tag, "_fidx"}, fidx8, 0);
        check({tag, "_vcnt"}, vcnt8, 0);
    endtask

    task automatic mon_check(input string tag, input res_t r, input logic pass, input logic [3:0] err,
                             input logic [3:0] fidx, input logic [3:0] vcnt, input logic busy);
        check({tag, "_pass"}, pass, r.pass);
        check({tag, "_err"},  err, r.err);
        check({tag, "_fidx"}, fidx, r.fidx);
        check({tag, "_vcnt"}, vcnt, r.vcnt);
        check({tag, "_busy"}, busy, 0);
    endtask

    always @(negedge CK) begin
        if (done8 && !pd8) begin
            if (exp8.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL done8_unexpected: got DONE=1 required no result pending");
            end else begin
                r8 = exp8.pop_front();
                mon_check("run8", r8, pass8, err8, fidx8, vcnt8, busy8);
            end
        end
        if (done16 && !pd16) begin
            if (exp16.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL done16_unexpected: got DONE=1 required no result pending");
            end else begin
                r16 = exp16.pop_front();
                mon_check("run16", r16, pass16, err16, fidx16, vcnt16, busy16);
            end
        end
        pd8  <= done8;
        pd16 <= done16;
    end

    logic [2:0] sweep [8];

    initial begin
        sweep = '{3'b000, 3'b011, 3'b110, 3'b111, 3'b010, 3'b101, 3'b011, 3'b111};
        repeat (3) @(posedge CK);
        #1 RST = 1'b0;
        check_zero("reset");
        check("reset_busy16", busy16, 0);
        check("reset_err16", err16, 0);

        // Cell sweep with correct responses
        for (int i = 0; i < 8; i++) begin
            vecs[i].d = sweep[i][2]; vecs[i].sn = sweep[i][1]; vecs[i].edg = sweep[i][0];
        end
        fill_good(8);
        run(8, 0);

        // Unknown first vector is skipped, then set with wrong Q
        fill_good(8);
        vecs[0].sn = 1'b1; vecs[0].edg = 1'b0; vecs[0].q = 1'b0; vecs[0].qn = 1'b1;
        vecs[1].sn = 1'b0; vecs[1].q = 1'b0; vecs[1].qn = 1'b1;
        run(8, 0);

        // Errors on vectors 2, 5, 6
        for (int i = 0; i < 8; i++) begin
            vecs[i].d = 1'($urandom_range(0, 1)); vecs[i].sn = 1'b1; vecs[i].edg = 1'b1;
        end
        fill_good(8);
        vecs[2].q = ~vecs[2].q; vecs[2].qn = ~vecs[2].q;
        vecs[5].q = ~vecs[5].q; vecs[5].qn = ~vecs[5].q;
        vecs[6].q = ~vecs[6].q; vecs[6].qn = ~vecs[6].q;
        run(8, 0);

        // X on Q for a known vector
        gen_random(8);
        fill_good(8);
        vecs[0].sn = 1'b0; vecs[0].q = 1'b1; vecs[0].qn = 1'b0;
        vecs[3].q = 1'bx;
        run(8, 0);

        // QN equal to Q on vector 4
        gen_random(8);
        fill_good(8);
        vecs[4].qn = vecs[4].q;
        run(8, 0);

        // 16 vectors, all wrong: saturation
        for (int i = 0; i < 16; i++) begin
            vecs[i].d = 1'($urandom_range(0, 1)); vecs[i].sn = 1'b1; vecs[i].edg = 1'b1;
            vecs[i].q = ~vecs[i].d; vecs[i].qn = vecs[i].d;
        end
        run(16, 1);

        // Reset mid-run discards the run
        gen_random(8);
        pulse_start(0);
        for (int i = 0; i < 3; i++) send(i);
        RST = 1'b1;
        @(posedge CK); #1;
        RST = 1'b0;
        check_zero("midrst");
        gen_random(8);
        fill_good(8);
        run(8, 0);

        // START mid-run restarts with cleared state; the coincident VLD is dropped
        gen_random(8);
        pulse_start(0);
        for (int i = 0; i < 3; i++) send(i);
        gen_random(8);
        exp8.push_back(model(8));
        start8 = 1'b1; VLD = 1'b1; Q = ~Q;
        @(posedge CK); #1;
        start8 = 1'b0; VLD = 1'b0;
        check("restart_vcnt", vcnt8, 0);
        check("restart_busy", busy8, 1);
        check("restart_err", err8, 0);
        for (int i = 0; i < 8; i++) send(i);
        repeat (2) begin @(posedge CK); #1; end

        for (int t = 0; t < 12; t++) begin
            gen_random(8);
            run(8, 0);
        end
        for (int t = 0; t < 2; t++) begin
            gen_random(16);
            run(16, 1);
        end

        for (int w = 0; w < 50 && (exp8.size() != 0 || exp16.size() != 0); w++) @(posedge CK);
        if (exp8.size() != 0 || exp16.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d results pending required 0", exp8.size() + exp16.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
